// File: rtl/setup_frame_deser.sv
// Serial setup deserialiser: LSB-first framed words gated by en_in are decoded into
// an address and data field and committed to a setup register bank. Optional macro: SETUP_PARITY_EN.
module setup_frame_deser #(
    parameter int FRAME_LEN = 32,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    localparam int NUM_REGS = 2 ** ADDR_W
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         serial_in,
    input  logic                         en_in,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         upd_out,
    output logic [ADDR_W-1:0]            upd_addr_out,
    output logic                         err_out,
    output logic                         busy_out,
    output logic [1:0]                   state_dbg_out
);

`ifdef SETUP_PARITY_EN
    localparam int TOTAL = FRAME_LEN + 1;
`else
    localparam int TOTAL = FRAME_LEN;
`endif
    localparam int CW = $clog2(FRAME_LEN + 2);
    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [DATA_W-1:0]            data_q, data_d;
    logic [NUM_REGS*DATA_W-1:0]   regs_q, regs_d;
    logic                         upd_q, upd_d;
    logic                         err_q, err_d;
    logic [ADDR_W-1:0]            upd_addr_q, upd_addr_d;
    logic                         busy_q, busy_d;
    logic                         sample;
    logic                         commit;
    logic [CW-1:0]                bit_idx;
`ifdef SETUP_PARITY_EN
    logic                         par_q, par_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        regs_d     = regs_q;
        upd_d      = 1'b0;
        err_d      = 1'b0;
        upd_addr_d = upd_addr_q;
        sample     = 1'b0;
        commit     = 1'b0;
        bit_idx    = (state_q == IDLE) ? '0 : cnt_q;
`ifdef SETUP_PARITY_EN
        par_d      = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (en_in) begin
                    sample  = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (en_in) begin
                    sample = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end else begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (en_in) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef SETUP_PARITY_EN
                    // par_q folds in the parity bit itself, so a good frame leaves it at zero
                    if (par_q) begin
                        err_d = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
`else
                    commit = 1'b1;
`endif
                end
            end
            DRAIN: begin
                if (!en_in) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (sample) begin
            for (int k = 0; k < ADDR_W; k++) begin
                if (bit_idx == CW'(k)) addr_d[k] = serial_in;
            end
            for (int k = 0; k < DATA_W; k++) begin
                if (bit_idx == CW'(FRAME_LEN - DATA_W + k)) data_d[k] = serial_in;
            end
`ifdef SETUP_PARITY_EN
            par_d = ((state_q == IDLE) ? 1'b0 : par_q) ^ serial_in;
`endif
        end

        if (commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (addr_q == ADDR_W'(k)) regs_d[k*DATA_W +: DATA_W] = data_q;
            end
            upd_d      = 1'b1;
            upd_addr_d = addr_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            regs_q     <= {NUM_REGS{RST_VAL}};
            upd_q      <= 1'b0;
            err_q      <= 1'b0;
            upd_addr_q <= '0;
            busy_q     <= 1'b0;
`ifdef SETUP_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            regs_q     <= regs_d;
            upd_q      <= upd_d;
            err_q      <= err_d;
            upd_addr_q <= upd_addr_d;
            busy_q     <= busy_d;
`ifdef SETUP_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign regs_out      = regs_q;
    assign upd_out       = upd_q;
    assign err_out       = err_q;
    assign upd_addr_out  = upd_addr_q;
    assign busy_out      = busy_q;
    assign state_dbg_out = state_q;

endmodule

// File: tb/tb_setup_frame_deser.sv
// Directed bench for setup_frame_deser: expected commit/error events are queued by the
// stimulus thread and popped by a monitor whenever the DUT pulses upd_out or err_out.
module tb_setup_frame_deser;

`ifdef SETUP_PARITY_EN
    localparam int TOT = 33;
`else
    localparam int TOT = 32;
`endif
    localparam logic [1:0] EV_UPD = 2'd1;
    localparam logic [1:0] EV_ERR = 2'd2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        serial_in = 1'b0;
    logic        en_in = 1'b0;
    logic [31:0] regs_out;
    logic        upd_out;
    logic [1:0]  upd_addr_out;
    logic        err_out;
    logic        busy_out;
    logic [1:0]  state_dbg_out;

    logic [35:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    setup_frame_deser dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .serial_in     (serial_in),
        .en_in         (en_in),
        .regs_out      (regs_out),
        .upd_out       (upd_out),
        .upd_addr_out  (upd_addr_out),
        .err_out       (err_out),
        .busy_out      (busy_out),
        .state_dbg_out (state_dbg_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ignored bits 2..23 carry a fixed non-zero pattern so stray capture shows up.
    function automatic logic [31:0] frame(input logic [1:0] a, input logic [7:0] d);
        return {d, 22'h2AAAAA, a};
    endfunction

    task automatic send_bits(input logic [31:0] word, input int nbits, input logic extra);
        for (int i = 0; i < nbits; i++) begin
            en_in = 1'b1;
            serial_in = (i < 32) ? word[i] : extra;
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic idle(input int n);
        en_in = 1'b0;
        serial_in = 1'b0;
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    always @(negedge clk_in) begin
        logic [35:0] item;
        if (upd_out || err_out) begin
            check("pulse_exclusive", {35'd0, upd_out && err_out}, 36'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", {err_out, upd_out, upd_addr_out, regs_out}, 36'd0);
            end else begin
                item = exp_q.pop_front();
                check("event", {err_out, upd_out, upd_addr_out, regs_out}, item);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected run to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;

        rst_in = 1'b1;
        idle(2);
        check("reset_regs", {4'd0, regs_out}, 36'd0);
        check("reset_upd", {35'd0, upd_out}, 36'd0);
        check("reset_err", {35'd0, err_out}, 36'd0);
        check("reset_busy", {35'd0, busy_out}, 36'd0);
        check("reset_upd_addr", {34'd0, upd_addr_out}, 36'd0);
        check("reset_state", {34'd0, state_dbg_out}, 36'd0);
        rst_in = 1'b0;
        idle(1);

        // Valid frame addr=2 data=A5
        w = frame(2'd2, 8'hA5);
        exp_q.push_back({EV_UPD, 2'd2, 32'h00A5_0000});
        send_bits(w, 1, ^w);
        check("busy_after_bit0", {35'd0, busy_out}, 36'd1);
        send_bits(w >> 1, TOT - 1, ^w);
        check("busy_in_done", {35'd0, busy_out}, 36'd1);
        idle(1);
        check("busy_after_commit", {35'd0, busy_out}, 36'd0);
        idle(2);

        // Short frame
        exp_q.push_back({EV_ERR, 2'd2, 32'h00A5_0000});
        send_bits(frame(2'd1, 8'h77), 20, 1'b0);
        idle(1);
        check("busy_after_short", {35'd0, busy_out}, 36'd0);
        idle(2);

        // Overrun frame
        exp_q.push_back({EV_ERR, 2'd2, 32'h00A5_0000});
        send_bits(frame(2'd0, 8'h11), TOT + 3, 1'b0);
        idle(1);
        check("regs_after_overrun", {4'd0, regs_out}, {4'd0, 32'h00A5_0000});
        idle(2);

        // Mid-frame reset at bit 10
        send_bits(frame(2'd1, 8'h55), 10, 1'b0);
        rst_in = 1'b1;
        en_in = 1'b1;
        @(posedge clk_in);
        #1;
        idle(1);
        rst_in = 1'b0;
        check("midreset_state", {34'd0, state_dbg_out}, 36'd0);
        check("midreset_busy", {35'd0, busy_out}, 36'd0);
        check("midreset_regs", {4'd0, regs_out}, 36'd0);
        check("midreset_err", {35'd0, err_out}, 36'd0);
        idle(1);

        // Back-to-back frames with one idle cycle between
        w = frame(2'd0, 8'h3C);
        exp_q.push_back({EV_UPD, 2'd0, 32'h0000_003C});
        send_bits(w, TOT, ^w);
        idle(1);
        w = frame(2'd3, 8'hFF);
        exp_q.push_back({EV_UPD, 2'd3, 32'hFF00_003C});
        send_bits(w, TOT, ^w);
        idle(3);
        check("b2b_regs", {4'd0, regs_out}, {4'd0, 32'hFF00_003C});

`ifdef SETUP_PARITY_EN
        w = frame(2'd1, 8'h01);
        exp_q.push_back({EV_ERR, 2'd3, 32'hFF00_003C});
        send_bits(w, TOT, ~(^w));
        idle(3);
        exp_q.push_back({EV_UPD, 2'd1, 32'hFF00_013C});
        send_bits(w, TOT, ^w);
        idle(3);
        check("parity_regs", {4'd0, regs_out}, {4'd0, 32'hFF00_013C});
`endif

        idle(4);
        check("queue_drained", 36'(exp_q.size()), 36'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
